// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a D/E pipeline: branch flush, load-use bubble and
// multicycle MUL/DIV/MOD stall sequencing, with stall and flush counters.
//
// state | meaning
// RUN   | normal issue; branch, multicycle start and load-use resolved here
// MDIV  | multicycle op occupying E; cnt counts down the remaining stall cycles
// LDUSE | one bubble inserted behind a load; returns to RUN
module pipeline_hazard_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  rs1D,
    input  logic [3:0]  rs2D,
    input  logic        useRs1D,
    input  logic        useRs2D,
    input  logic [3:0]  rdE,
    input  logic        validE,
    input  logic        isWbE,
    input  logic        isLdE,
    input  logic        isMulE,
    input  logic        isDivE,
    input  logic        isModE,
    input  logic        isBranchTakenE,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        flushD,
    output logic        flushE,
    output logic        aluDone,
    output logic [1:0]  stallC,
    output logic [15:0] stallCycles,
    output logic [15:0] flushCount
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        MDIV  = 2'b01,
        LDUSE = 2'b10,
        BAD   = 2'b11
    } state_t;

    // The start cycle and the done cycle are not counted down, hence lat-2.
    localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 2);
    localparam logic [3:0] DIV_INIT = 4'(DIV_LAT - 2);

    state_t     state;
    state_t     stateNext;
    logic [3:0] cnt;
    logic [3:0] cntNext;
    logic       ldUse;
    logic       mdStart;
    logic       brTaken;

    assign ldUse = validE & isLdE & isWbE & (rdE != 4'd0) &
                   ((useRs1D & (rs1D == rdE)) | (useRs2D & (rs2D == rdE)));
    assign mdStart = validE & (isMulE | isDivE | isModE);
    assign brTaken = validE & isBranchTakenE;

    assign stallC = state;

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        aluDone   = 1'b0;
        // Outputs are held low while reset is asserted, regardless of inputs.
        if (reset) begin
            case (state)
                RUN: begin
                    if (brTaken) begin
                        flushD = 1'b1;
                        flushE = 1'b1;
                    end else if (mdStart) begin
                        stallF    = 1'b1;
                        stallD    = 1'b1;
                        stallE    = 1'b1;
                        cntNext   = isMulE ? MUL_INIT : DIV_INIT;
                        stateNext = MDIV;
                    end else if (ldUse) begin
                        stallF    = 1'b1;
                        stallD    = 1'b1;
                        flushE    = 1'b1;
                        stateNext = LDUSE;
                    end
                end
                MDIV: begin
                    if (cnt != 4'd0) begin
                        stallF  = 1'b1;
                        stallD  = 1'b1;
                        stallE  = 1'b1;
                        cntNext = cnt - 4'd1;
                    end else begin
                        aluDone   = 1'b1;
                        stateNext = RUN;
                    end
                end
                LDUSE: begin
                    stateNext = RUN;
                end
                default: begin
                    cntNext   = 4'd0;
                    stateNext = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCycles <= 16'd0;
            flushCount  <= 16'd0;
        end else begin
            if (stallF && (stallCycles != 16'hFFFF))
                stallCycles <= stallCycles + 16'd1;
            if (flushD && (flushCount != 16'hFFFF))
                flushCount <= flushCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-budget model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 8;

    logic        clk;
    logic        reset;
    logic [3:0]  rs1D, rs2D, rdE;
    logic        useRs1D, useRs2D, validE, isWbE, isLdE;
    logic        isMulE, isDivE, isModE, isBranchTakenE;
    logic        stallF, stallD, stallE, flushD, flushE, aluDone;
    logic [1:0]  stallC;
    logic [15:0] stallCycles, flushCount;

    int compared = 0;
    int mismatched = 0;

    // Model: remaining cycles of an ongoing multicycle op (done cycle included),
    // pending load-use bubble, and expected counter values.
    int mdLeft = 0;
    bit ldPend = 0;
    int sCnt = 0;
    int fCnt = 0;

    pipeline_hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset),
        .rs1D(rs1D), .rs2D(rs2D), .useRs1D(useRs1D), .useRs2D(useRs2D),
        .rdE(rdE), .validE(validE), .isWbE(isWbE), .isLdE(isLdE),
        .isMulE(isMulE), .isDivE(isDivE), .isModE(isModE),
        .isBranchTakenE(isBranchTakenE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .aluDone(aluDone),
        .stallC(stallC), .stallCycles(stallCycles), .flushCount(flushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {stallF, stallD, stallE, flushD, flushE, aluDone};
    endfunction

    function automatic bit modelHazard();
        return validE && isLdE && isWbE && rdE != 0 &&
               ((useRs1D && rs1D == rdE) || (useRs2D && rs2D == rdE));
    endfunction

    // Expected {stallF, stallD, stallE, flushD, flushE, aluDone}.
    function automatic logic [5:0] expOuts();
        if (!reset) return 6'b000000;
        if (mdLeft > 1) return 6'b111000;
        if (mdLeft == 1) return 6'b000001;
        if (ldPend) return 6'b000000;
        if (validE && isBranchTakenE) return 6'b000110;
        if (validE && (isMulE || isDivE || isModE)) return 6'b111000;
        if (modelHazard()) return 6'b110010;
        return 6'b000000;
    endfunction

    function automatic logic [1:0] expState();
        if (mdLeft > 0) return 2'b01;
        if (ldPend) return 2'b10;
        return 2'b00;
    endfunction

    task automatic setIn(input logic v, ld, wb, mul, dv, md, br,
                         input logic [3:0] rd, r1, r2, input logic u1, u2);
        validE = v; isLdE = ld; isWbE = wb; isMulE = mul; isDivE = dv;
        isModE = md; isBranchTakenE = br; rdE = rd; rs1D = r1; rs2D = r2;
        useRs1D = u1; useRs2D = u2;
    endtask

    task automatic idle();
        setIn(0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
    endtask

    // Advances one clock edge and moves the model along with it.
    task automatic tick();
        logic [5:0] e;
        e = expOuts();
        if (reset) begin
            if (e[5] && sCnt < 65535) sCnt++;
            if (e[2] && fCnt < 65535) fCnt++;
            if (mdLeft > 0) mdLeft--;
            else if (ldPend) ldPend = 0;
            else if (validE && isBranchTakenE) ;
            else if (validE && (isMulE || isDivE || isModE))
                mdLeft = (isMulE ? MUL_LAT : DIV_LAT) - 1;
            else if (modelHazard()) ldPend = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        idle();
        mdLeft = 0; ldPend = 0; sCnt = 0; fCnt = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        doReset();
        setIn(1, 0, 0, 0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
        tick();
        idle();
        tick();
        // Asserted mid-cycle while a divide is stalling the pipe.
        #2;
        reset = 1'b0;
        mdLeft = 0; ldPend = 0; sCnt = 0; fCnt = 0;
        #1;
        compared++;
        if (outs() !== 6'b000000 || stallC !== 2'b00 || stallCycles !== 16'd0 || flushCount !== 16'd0) begin
            mismatched++;
            $display("FAIL reset_async outs=%b stallC=%b sc=%0d fc=%0d required 000000/00/0/0",
                     outs(), stallC, stallCycles, flushCount);
        end
        // Events on the inputs must not leak through while reset is held.
        setIn(1, 1, 1, 0, 1, 0, 1, 4'd2, 4'd2, 4'd0, 1, 0);
        #1;
        compared++;
        if (outs() !== 6'b000000) begin
            mismatched++;
            $display("FAIL reset_gating outs=%b required 000000", outs());
        end
        idle();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ld_use();
        doReset();
        setIn(1, 1, 1, 0, 0, 0, 0, 4'd2, 4'd2, 4'd7, 1, 0);
        #2;
        compared++;
        if (outs() !== 6'b110010) begin
            mismatched++;
            $display("FAIL ld_use_cycle outs=%b required 110010", outs());
        end
        tick();
        idle();
        #2;
        compared++;
        if (stallC !== 2'b10 || outs() !== 6'b000000) begin
            mismatched++;
            $display("FAIL ld_use_bubble stallC=%b outs=%b required 10/000000", stallC, outs());
        end
        tick();
        compared++;
        if (stallC !== 2'b00 || stallCycles !== 16'd1) begin
            mismatched++;
            $display("FAIL ld_use_after stallC=%b sc=%0d required 00/1", stallC, stallCycles);
        end
    endtask

    task automatic test_no_hazard();
        doReset();
        setIn(1, 1, 1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 1, 1);
        #2;
        compared++;
        if (outs() !== 6'b000000) begin
            mismatched++;
            $display("FAIL no_hazard_rd0 outs=%b required 000000", outs());
        end
        tick();
        setIn(1, 1, 1, 0, 0, 0, 0, 4'd2, 4'd2, 4'd5, 0, 0);
        #2;
        compared++;
        if (outs() !== 6'b000000 || stallC !== 2'b00) begin
            mismatched++;
            $display("FAIL no_hazard_nouse outs=%b stallC=%b required 000000/00", outs(), stallC);
        end
        tick();
        compared++;
        if (stallC !== 2'b00 || stallCycles !== 16'd0) begin
            mismatched++;
            $display("FAIL no_hazard_after stallC=%b sc=%0d required 00/0", stallC, stallCycles);
        end
    endtask

    task automatic test_multicycle(input bit isMul, input int lat);
        logic [5:0] want;
        logic [1:0] wantC;
        doReset();
        setIn(1, 0, 0, isMul, !isMul, 0, 0, 4'd3, 4'd0, 4'd0, 0, 0);
        for (int k = 1; k <= lat; k++) begin
            #2;
            want  = (k < lat) ? 6'b111000 : 6'b000001;
            wantC = (k >= 2) ? 2'b01 : 2'b00;
            compared++;
            if (outs() !== want || stallC !== wantC) begin
                mismatched++;
                $display("FAIL md_lat%0d_cycle%0d outs=%b stallC=%b required %b/%b",
                         lat, k, outs(), stallC, want, wantC);
            end
            tick();
            // Later E flags are ignored; present a new divide to prove it.
            setIn(1, 0, 0, 0, 1, 0, 1, 4'd0, 4'd0, 4'd0, 0, 0);
        end
        idle();
        compared++;
        if (stallCycles !== 16'(lat - 1) || stallC !== 2'b00) begin
            mismatched++;
            $display("FAIL md_lat%0d_total sc=%0d stallC=%b required %0d/00",
                     lat, stallCycles, stallC, lat - 1);
        end
    endtask

    task automatic test_branch_priority();
        doReset();
        setIn(1, 1, 1, 0, 0, 0, 1, 4'd2, 4'd2, 4'd2, 1, 1);
        #2;
        compared++;
        if (outs() !== 6'b000110) begin
            mismatched++;
            $display("FAIL br_over_ld outs=%b required 000110", outs());
        end
        tick();
        idle();
        compared++;
        if (flushCount !== 16'd1 || stallC !== 2'b00 || stallCycles !== 16'd0) begin
            mismatched++;
            $display("FAIL br_after fc=%0d stallC=%b sc=%0d required 1/00/0",
                     flushCount, stallC, stallCycles);
        end
    endtask

    task automatic test_reset_mid_mdiv();
        doReset();
        setIn(1, 0, 0, 0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
        tick();
        idle();
        tick();
        tick();
        // cnt now at 4
        #2;
        reset = 1'b0;
        mdLeft = 0; ldPend = 0; sCnt = 0; fCnt = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            #2;
            compared++;
            if (outs() !== 6'b000000 || stallC !== 2'b00) begin
                mismatched++;
                $display("FAIL reset_mdiv_cycle%0d outs=%b stallC=%b required 000000/00",
                         k, outs(), stallC);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int errs = 0;
        doReset();
        for (int n = 0; n < 1500; n++) begin
            setIn($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0,
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  4'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1));
            #2;
            compared++;
            if (outs() !== expOuts() || stallC !== expState() ||
                stallCycles !== 16'(sCnt) || flushCount !== 16'(fCnt)) begin
                mismatched++;
                if (errs++ < 10)
                    $display("FAIL random_%0d outs=%b stallC=%b sc=%0d fc=%0d required %b/%b/%0d/%0d",
                             n, outs(), stallC, stallCycles, flushCount,
                             expOuts(), expState(), sCnt, fCnt);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_flush_saturation();
        doReset();
        setIn(1, 0, 0, 0, 0, 0, 1, 4'd0, 4'd0, 4'd0, 0, 0);
        for (int n = 0; n < 65536; n++) tick();
        compared++;
        if (flushCount !== 16'hFFFF || fCnt != 65535) begin
            mismatched++;
            $display("FAIL flush_sat fc=%h required ffff", flushCount);
        end
        tick();
        tick();
        idle();
        compared++;
        if (flushCount !== 16'hFFFF) begin
            mismatched++;
            $display("FAIL flush_hold fc=%h required ffff", flushCount);
        end
    endtask

    initial begin
        reset = 1'b0;
        idle();
        test_reset();
        test_ld_use();
        test_no_hazard();
        test_multicycle(1'b0, DIV_LAT);
        test_multicycle(1'b1, MUL_LAT);
        test_branch_priority();
        test_reset_mid_mdiv();
        test_random();
        test_flush_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 2: total E-stage occupancy of MUL in cycles; legal range 2..16.
REQ-002 SHALL have parameter DIV_LAT, default 8: total E-stage occupancy of DIV/MOD in cycles; legal range 2..16.
REQ-003 SHALL have ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rs1D, rs2D  in  4  source registers of the instruction in D.
- useRs1D, useRs2D  in  1  the instruction in D actually reads rs1D / rs2D.
- rdE  in  4  destination register of the instruction in E.
- validE  in  1  E holds a real instruction, not a bubble.
- isWbE, isLdE, isMulE, isDivE, isModE  in  1  control flags of the instruction in E.
- isBranchTakenE  in  1  the branch in E resolved taken.
- stallF, stallD, stallE  out  1  hold the PC, the D register and the E register respectively.
- flushD, flushE  out  1  load a bubble into the D / E register at the next edge.
- aluDone  out  1  multicycle result valid this cycle.
- stallC  out  2  state: 00 RUN, 01 MDIV, 10 LDUSE.
- stallCycles, flushCount  out  16  performance counters.

Function
REQ-004 ldUse SHALL be validE & isLdE & isWbE & rdE!=0 & ((useRs1D & rs1D==rdE) | (useRs2D & rs2D==rdE)).
REQ-005 mdStart SHALL be validE & (isMulE | isDivE | isModE); lat = MUL_LAT when isMulE, else DIV_LAT.
REQ-006 brTaken SHALL be validE & isBranchTakenE.
REQ-007 In RUN, events SHALL resolve in priority order brTaken > mdStart > ldUse; lower-priority events in the same cycle are ignored.
REQ-008 RUN & brTaken: flushD=flushE=1 combinationally in the same cycle; no stalls; next state RUN.
REQ-009 RUN & mdStart: stallF=stallD=stallE=1 in the same cycle; cnt <= lat-2; next state MDIV.
REQ-010 RUN & ldUse: stallF=stallD=1 and flushE=1 in the same cycle; stallE=0; next state LDUSE.
REQ-011 MDIV with cnt!=0: stallF=stallD=stallE=1; cnt decrements; E-stage flags are ignored.
REQ-012 MDIV with cnt==0: all stalls 0; aluDone=1 for exactly this cycle; next state RUN.
REQ-013 LDUSE: all stall and flush outputs 0; next state RUN unconditionally.
REQ-014 With no event in RUN, all stall, flush and aluDone outputs SHALL be 0.
REQ-015 Total stall cycles for a multicycle op SHALL be lat-1; E occupancy SHALL be lat cycles.
REQ-016 stallCycles SHALL increment on every edge where stallF=1, saturating at 0xFFFF.
REQ-017 flushCount SHALL increment on every edge where flushD=1, saturating at 0xFFFF.
REQ-018 cnt SHALL be 4 bits; unused FSM encoding 11 SHALL return to RUN with all outputs 0.
REQ-019 stallC SHALL be a registered state output; stall/flush/aluDone SHALL be combinational from state, cnt and inputs.

Reset
REQ-020 reset=0 SHALL immediately force state RUN, cnt=0 and both counters to 0; all stall/flush/aluDone outputs 0, independent of clk.
REQ-021 Reset asserted mid-MDIV or mid-LDUSE SHALL abandon the operation without an aluDone pulse.
REQ-022 After reset release, the first edge SHALL evaluate RUN rules normally.

Verification
REQ-023 Reset at arbitrary time -> stallC=00, all 1-bit outputs 0, stallCycles=flushCount=0 within the same timestep.
REQ-024 validE=1, isLdE=isWbE=1, rdE=2, rs1D=2, useRs1D=1 -> that cycle stallF=stallD=flushE=1, stallE=0; next cycle stallC=10 with outputs 0; then stallC=00; stallCycles=1.
REQ-025 Same stimulus with rdE=0, or useRs1D=0 -> no stall; stallC stays 00.
REQ-026 DIV_LAT=8, isDivE pulse with validE -> stallF/D/E high for 7 consecutive cycles; stallC=01 for cycles 2..8; aluDone high only in cycle 8; stallCycles=7. MUL with MUL_LAT=2 -> 1 stall cycle, aluDone in cycle 2.
REQ-027 brTaken together with ldUse -> flushD=flushE=1, stallF=0, flushCount+1, stallC stays 00; 65536 flush cycles -> flushCount holds at 0xFFFF.
REQ-028 reset=0 during MDIV at cnt=4, released with validE=0 -> stallC=00, no stalls, no aluDone.
